// File: rtl/keypad_event_ctrl_if.sv
// keypad_event_ctrl_if: bundles the keypad rows, scanner handshake and key-event stream.
// Latency: none (wires only).
// Backpressure: key_valid/key_ready on the event side; master = controller, slave = environment.
interface keypad_event_ctrl_if;
  logic [3:0] Row_raw;
  logic [3:0] Row;
  logic       S_Row;
  logic [3:0] Code_in;
  logic       Valid_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic       clear_ovf;

  modport master (
    input  Row_raw, Code_in, Valid_in, key_ready, clear_ovf,
    output Row, S_Row, key_code, key_valid, overflow
  );

  modport slave (
    output Row_raw, Code_in, Valid_in, key_ready, clear_ovf,
    input  Row, S_Row, key_code, key_valid, overflow
  );
endinterface

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: syncs/debounces keypad rows, strobes the scanner, queues one code per press.
// Latency: rows 2 cycles; a pushed code shows on key_valid/key_code the cycle after the push.
// Backpressure: FWFT FIFO popped on key_valid&&key_ready; push into a full FIFO without a pop is dropped and sets sticky overflow.
// Optional auto-repeat while a key stays held: define KEY_REPEAT_EN.
module keypad_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_TIMEOUT    = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 200,
  parameter int REPEAT_PERIOD   = 50
) (
  input  logic                clock,
  input  logic                reset,
  keypad_event_ctrl_if.master kp
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_TIMEOUT) ? DEBOUNCE_CYCLES : SCAN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, CAPTURE, HELD} state_t;

  state_t           state;
  logic [3:0]       row_s1;
  logic [3:0]       row_q;
  logic [3:0]       row_ref;
  logic [CNT_W-1:0] cnt;
  logic             s_row_q;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [3:0]       key_code_q;
  logic             ovf_q;

  logic             fifo_empty;
  logic             fifo_full;
  logic             cap_push;
  logic             rep_push;
  logic             push_req;
  logic [3:0]       push_dat;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;
  logic [PW-1:0]    rd_next;
  logic [PW-1:0]    wr_next;
  logic [3:0]       head_next;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cap_push   = (state == CAPTURE) && kp.Valid_in;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic [3:0]       held_code;
  logic [REP_W-1:0] rep_target;

  assign rep_target = rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
  assign rep_push   = (state == HELD) && (row_q != 4'd0) && (rep_cnt == rep_target);
  assign push_dat   = cap_push ? kp.Code_in : held_code;

  // Repeat timer: restarts whenever HELD is (re)entered, advances only while the key is down.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      held_code <= 4'd0;
    end else begin
      if (cap_push) held_code <= kp.Code_in;
      if (state != HELD) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (row_q != 4'd0) begin
        if (rep_push) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign rep_push = 1'b0;
  assign push_dat = kp.Code_in;
`endif

  assign push_req = cap_push | rep_push;
  assign pop      = !fifo_empty && kp.key_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  assign rd_next  = rd_ptr + {{AW{1'b0}}, pop};
  assign wr_next  = wr_ptr + {{AW{1'b0}}, push_ok};
  // New head is the incoming code only when it lands in the slot the read pointer moves to.
  assign head_next = (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) ? push_dat
                                                                       : mem[rd_next[AW-1:0]];

  // Two-flop synchroniser for the raw row lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_s1 <= 4'd0;
      row_q  <= 4'd0;
    end else begin
      row_s1 <= kp.Row_raw;
      row_q  <= row_s1;
    end
  end

  // Press/scan/release sequencer; S_Row is registered and high exactly while in CAPTURE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_ref <= 4'd0;
      cnt     <= '0;
      s_row_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (row_q != 4'd0) begin
            row_ref <= row_q;
            cnt     <= '0;
            state   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if ((row_q != row_ref) || (row_q == 4'd0)) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt     <= '0;
            state   <= CAPTURE;
            s_row_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (kp.Valid_in) begin
            cnt     <= '0;
            state   <= HELD;
            s_row_q <= 1'b0;
          end else if (cnt == CNT_W'(SCAN_TIMEOUT - 1)) begin
            cnt     <= '0;
            state   <= IDLE;
            s_row_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (row_q == 4'd0) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Event storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // FIFO pointers, registered head (holds when empty) and sticky overflow (set beats clear).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      key_code_q <= 4'd0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (wr_next != rd_next) key_code_q <= head_next;
      if (ovf_set)           ovf_q <= 1'b1;
      else if (kp.clear_ovf) ovf_q <= 1'b0;
    end
  end

  assign kp.Row       = row_q;
  assign kp.S_Row     = s_row_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = !fifo_empty;
  assign kp.overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl with default parameters (debounce 16, timeout 8, depth 4).
module tb_keypad_event_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  keypad_event_ctrl_if kp();

  keypad_event_ctrl dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One press: wait for the scan strobe, optionally answer with a code held 2 cycles,
  // then release and let the release debounce finish.
  task automatic press(input logic [3:0] row, input logic [3:0] code, input bit give_valid,
                       input bit pop_on_push, output int srow_cycles, output logic kv_after,
                       output logic srow_after);
    bit found;
    found       = 1'b0;
    srow_cycles = 0;
    kv_after    = 1'b0;
    srow_after  = 1'b0;
    kp.Row_raw  = row;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (kp.S_Row) begin
        found = 1'b1;
        break;
      end
    end
    check("strobe_seen", {31'd0, found}, 32'd1);
    if (found && give_valid) begin
      kp.Valid_in  = 1'b1;
      kp.Code_in   = code;
      kp.key_ready = pop_on_push;
      srow_cycles  = 1;
      @(negedge clock);
      kv_after     = kp.key_valid;
      srow_after   = kp.S_Row;
      kp.key_ready = 1'b0;
      @(negedge clock);
      kp.Valid_in  = 1'b0;
    end else if (found) begin
      while (kp.S_Row && srow_cycles < 20) begin
        srow_cycles++;
        @(negedge clock);
      end
    end
    kp.Row_raw = 4'd0;
    tick(24);
  endtask

  task automatic drain_one(input string tag, input logic [3:0] exp);
    check({tag, "_valid"}, {31'd0, kp.key_valid}, 32'd1);
    check({tag, "_code"}, {28'd0, kp.key_code}, {28'd0, exp});
    kp.key_ready = 1'b1;
    @(negedge clock);
    kp.key_ready = 1'b0;
  endtask

  int   sc;
  logic kv;
  logic sr;
  int   strobes;

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    kp.Row_raw   = 4'd0;
    kp.Code_in   = 4'd0;
    kp.Valid_in  = 1'b0;
    kp.key_ready = 1'b0;
    kp.clear_ovf = 1'b0;
    tick(3);

    // Reset values
    check("rst_row", {28'd0, kp.Row}, 32'd0);
    check("rst_srow", {31'd0, kp.S_Row}, 32'd0);
    check("rst_kvalid", {31'd0, kp.key_valid}, 32'd0);
    check("rst_kcode", {28'd0, kp.key_code}, 32'd0);
    check("rst_ovf", {31'd0, kp.overflow}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Single press, code A; synchroniser delay is two cycles
    kp.Row_raw = 4'b0100;
    tick(1);
    check("sync_1cyc", {28'd0, kp.Row}, 32'd0);
    tick(1);
    check("sync_2cyc", {28'd0, kp.Row}, 32'h4);
    press(4'b0100, 4'hA, 1'b1, 1'b0, sc, kv, sr);
    check("single_kvalid_next", {31'd0, kv}, 32'd1);
    check("single_srow_drop", {31'd0, sr}, 32'd0);
    drain_one("single", 4'hA);
    check("single_one_event", {31'd0, kp.key_valid}, 32'd0);
    check("single_code_hold", {28'd0, kp.key_code}, 32'hA);

    // Bounce: 0010/0000 every 3 cycles for 30 cycles, then quiet
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      kp.Row_raw = ((i / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
      @(negedge clock);
      if (kp.S_Row) strobes++;
    end
    kp.Row_raw = 4'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (kp.S_Row) strobes++;
    end
    check("bounce_no_strobe", strobes, 32'd0);
    check("bounce_no_event", {31'd0, kp.key_valid}, 32'd0);

    // Overflow: five presses, nobody pops
    for (int k = 1; k <= 5; k++) begin
      press(4'b0001, 4'(k), 1'b1, 1'b0, sc, kv, sr);
    end
    check("ovf_set", {31'd0, kp.overflow}, 32'd1);
    kp.clear_ovf = 1'b1;
    tick(1);
    kp.clear_ovf = 1'b0;
    check("ovf_cleared", {31'd0, kp.overflow}, 32'd0);
    drain_one("ovf_d1", 4'h1);
    drain_one("ovf_d2", 4'h2);
    drain_one("ovf_d3", 4'h3);
    drain_one("ovf_d4", 4'h4);
    check("ovf_drained", {31'd0, kp.key_valid}, 32'd0);

    // Full FIFO with pop in the push cycle: no drop, new code last
    for (int k = 6; k <= 9; k++) begin
      press(4'b1000, 4'(k), 1'b1, 1'b0, sc, kv, sr);
    end
    press(4'b1000, 4'hB, 1'b1, 1'b1, sc, kv, sr);
    check("full_pp_no_ovf", {31'd0, kp.overflow}, 32'd0);
    drain_one("full_d1", 4'h7);
    drain_one("full_d2", 4'h8);
    drain_one("full_d3", 4'h9);
    drain_one("full_d4", 4'hB);
    check("full_drained", {31'd0, kp.key_valid}, 32'd0);

    // Scan timeout with two entries queued
    press(4'b0010, 4'hC, 1'b1, 1'b0, sc, kv, sr);
    press(4'b0010, 4'hD, 1'b1, 1'b0, sc, kv, sr);
    press(4'b0001, 4'h0, 1'b0, 1'b0, sc, kv, sr);
    check("timeout_srow_len", sc, 32'd8);
    check("timeout_kvalid", {31'd0, kp.key_valid}, 32'd1);
    check("timeout_head", {28'd0, kp.key_code}, 32'hC);

    // Reset in the middle of a debounce with entries queued
    kp.Row_raw = 4'b0010;
    tick(6);
    reset      = 1'b1;
    kp.Row_raw = 4'd0;
    #1;
    check("midrst_kvalid", {31'd0, kp.key_valid}, 32'd0);
    check("midrst_ovf", {31'd0, kp.overflow}, 32'd0);
    check("midrst_kcode", {28'd0, kp.key_code}, 32'd0);
    check("midrst_row", {28'd0, kp.Row}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(2);
    check("postrst_empty", {31'd0, kp.key_valid}, 32'd0);
    press(4'b1000, 4'h5, 1'b1, 1'b0, sc, kv, sr);
    drain_one("postrst", 4'h5);

`ifdef KEY_REPEAT_EN
    // Hold 0x7 for 400 cycles with an instant-response scanner and constant pop
    begin
      int ev_n;
      int ev_t [8];
      ev_n = 0;
      kp.key_ready = 1'b1;
      kp.Code_in   = 4'h7;
      kp.Row_raw   = 4'b0100;
      for (int i = 0; i < 460; i++) begin
        if (i == 400) kp.Row_raw = 4'd0;
        kp.Valid_in = kp.S_Row;
        @(negedge clock);
        if (kp.key_valid) begin
          if (ev_n < 8) ev_t[ev_n] = i;
          ev_n++;
          check("rep_code", {28'd0, kp.key_code}, 32'h7);
        end
      end
      kp.Valid_in  = 1'b0;
      kp.key_ready = 1'b0;
      check("rep_count", ev_n, 32'd5);
      if (ev_n >= 5) begin
        check("rep_gap1", ev_t[1] - ev_t[0], 32'd200);
        check("rep_gap2", ev_t[2] - ev_t[1], 32'd50);
        check("rep_gap3", ev_t[3] - ev_t[2], 32'd50);
        check("rep_gap4", ev_t[4] - ev_t[3], 32'd50);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
